chunked_wide_adder: RTL



---
 rtl/chunked_wide_adder_pkg.sv | 21 ++
 rtl/chunked_wide_adder_cla.sv | 41 ++++
 rtl/chunked_wide_adder.sv | 112 +++++++++++
 3 files changed

// File: rtl/chunked_wide_adder_pkg.sv
// rtl/chunked_wide_adder_pkg.sv - shared state encoding and sizing for the chunked wide adder
package chunked_wide_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CWA_CHUNK  = 4;
  localparam int CWA_CHUNKS = 4;
  localparam int CWA_N      = CWA_CHUNK * CWA_CHUNKS;

  // Slice index width; never narrower than one bit.
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

  localparam int CWA_IDX_W = idx_width(CWA_CHUNKS);

endpackage

// File: rtl/chunked_wide_adder_cla.sv
// rtl/chunked_wide_adder_cla.sv - WIDTH-bit carry-lookahead adder slice
module chunked_wide_adder_cla #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;
  logic             w_term;
  logic             w_prod;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is the flat sum of products g[j]&p[i..j+1] plus cin&p[i..0].
  always_comb begin
    w_term = 1'b0;
    w_prod = 1'b1;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_term = 1'b0;
      w_prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        w_term = w_term | (w_prod & w_g[j]);
        w_prod = w_prod & w_p[j];
      end
      w_c[i+1] = w_term | (w_prod & cin);
    end
  end

  assign s    = w_p ^ w_c[WIDTH-1:0];
  assign cout = w_c[WIDTH];

endmodule

// File: rtl/chunked_wide_adder.sv
// rtl/chunked_wide_adder.sv - multi-cycle wide add/sub sequencing one lookahead slice per cycle
module chunked_wide_adder
  import chunked_wide_adder_pkg::*;
#(
  parameter  int CHUNK  = CWA_CHUNK,
  parameter  int CHUNKS = CWA_CHUNKS,
  localparam int N      = CHUNK * CHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int IDX_W = idx_width(CHUNKS);

  state_t             r_state;
  logic [N-1:0]       r_opa;
  logic [N-1:0]       r_opb;
  logic [N-CHUNK-1:0] r_psum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_out_valid;
  logic [N-1:0]       r_s;
  logic               r_cout;
  logic               r_ovf;

  logic [CHUNK-1:0]   w_sum;
  logic               w_cout;
  logic [N-1:0]       w_psum_next;

  chunked_wide_adder_cla #(.WIDTH(CHUNK)) adder (
    .a    (r_opa[CHUNK-1:0]),
    .b    (r_opb[CHUNK-1:0]),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Slice sums enter at the top so the LSB slice ends up at bit 0.
  assign w_psum_next = {w_sum, r_psum};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_opa       <= '0;
      r_opb       <= '0;
      r_psum      <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opa    <= a;
            r_opb    <= sub ? ~b : b;
            r_carry  <= sub ? 1'b1 : cin;
            r_idx    <= '0;
            r_sign_a <= a[N-1];
            r_sign_b <= sub ? ~b[N-1] : b[N-1];
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_opa   <= r_opa >> CHUNK;
          r_opb   <= r_opb >> CHUNK;
          r_psum  <= w_psum_next[N-1:CHUNK];
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(CHUNKS - 1)) begin
            r_state     <= DONE;
            r_s         <= w_psum_next;
            r_cout      <= w_cout;
            r_ovf       <= (r_sign_a == r_sign_b) && (w_sum[CHUNK-1] != r_sign_a);
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
